// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and slot state encoding for demux1_4_buf
package demux_pkg;

    localparam int DEMUX_PORTS = 4;
    localparam int DEMUX_SEL_W = 2;
    localparam int DEMUX_WIDTH = 32;
    localparam int XFER_CNT_W  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux1_4_buf_port_slot.sv
// rtl/demux1_4_buf_port_slot.sv - one-entry holding register with EMPTY/FULL state
module port_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_t      state;
    logic [WIDTH-1:0] data_q;

    // Slot FSM: a load always leaves the slot FULL (covers drain+load with no bubble);
    // a drain without a load empties it. Data only moves on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (drain && !load) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
            if (load) begin
                data_q <= load_data;
            end
        end
    end

    assign valid = (state == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/demux1_4_buf.sv
// rtl/demux1_4_buf.sv - buffered 1-to-4 word distributor with per-port holding slots
module demux1_4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [DEMUX_SEL_W-1:0] sel,
    output logic [DEMUX_PORTS-1:0] out_valid,
    input  logic [DEMUX_PORTS-1:0] out_ready,
    output logic [WIDTH-1:0]       out_data0,
    output logic [WIDTH-1:0]       out_data1,
    output logic [WIDTH-1:0]       out_data2,
    output logic [WIDTH-1:0]       out_data3,
    output logic [XFER_CNT_W-1:0]  xfer_cnt
);

    logic                   acc;
    logic [DEMUX_PORTS-1:0] load_vec;
    logic [DEMUX_PORTS-1:0] drain_vec;
    logic [WIDTH-1:0]       slot_data [DEMUX_PORTS];

    // Only the selected slot gates upstream; a stalled non-selected slot never blocks.
    assign in_ready  = !rst && (!out_valid[sel] || out_ready[sel]);
    assign acc       = in_valid && in_ready;
    assign load_vec  = acc ? (DEMUX_PORTS'(1) << sel) : '0;
    assign drain_vec = out_valid & out_ready;

    for (genvar k = 0; k < DEMUX_PORTS; k++) begin : g_slot
        port_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[k]),
            .load_data(in_data),
            .drain    (drain_vec[k]),
            .valid    (out_valid[k]),
            .data     (slot_data[k])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

    // Accepted-word counter, wraps naturally at 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (acc) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 word distributor: one upstream 32-bit valid/ready stream is steered by a 2-bit select into one of four downstream ports. Each port owns a one-entry holding register, so a slow destination back-pressures only while it is the one selected. It sits between the CPU store/writeback path and four consumers (I/O peripherals, result sinks), complementing the 4:1 select muxes on the read side.

## Interface
Parameters:
- `WIDTH`, 32, data width of all ports.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  upstream word accepted this cycle when `in_valid` is also high.
- `in_data`  in  WIDTH  upstream word.
- `sel`  in  2  destination port index; sampled with `in_data`.
- `out_valid`  out  4  bit k: port k holds a word.
- `out_ready`  in  4  bit k: consumer k takes the word this cycle.
- `out_data0`..`out_data3`  out  WIDTH each  holding-register contents of port k.
- `xfer_cnt`  out  16  count of accepted upstream words, wraps at 65535 -> 0.

## Operation
- Each port slot is a 2-state FSM: EMPTY (`out_valid[k]`=0), FULL (`out_valid[k]`=1).
- Drain of port k: `out_valid[k] & out_ready[k]`.
- Upstream accept: `acc = in_valid & in_ready`.
- `in_ready = !rst & (!out_valid[sel] | out_ready[sel])`. Only the selected port matters; a FULL, stalled non-selected port never blocks.
- Accept with `sel`=k: `out_data<k>` <= `in_data`; port k becomes/stays FULL.
- Slot transitions:
  - EMPTY -> FULL on accept to k.
  - FULL -> EMPTY on drain without accept to k.
  - FULL -> FULL on drain plus accept to k in the same cycle; the new word replaces the old with no bubble.
  - FULL stays FULL with data unchanged when not drained.
- `out_data<k>` changes only on accept to k. Data is held stable while FULL and undrained.
- Ports are independent. Several ports may drain in the same cycle. At most one port is filled per cycle.
- `xfer_cnt` increments by 1 on each accept, modulo 2^16.
- `out_ready[k]` while port k is EMPTY is ignored.
- `in_data`/`sel` while `in_valid`=0 are ignored.

## Timing
- Reset values: `out_valid`=4'b0000, `out_data0..3`=0, `xfer_cnt`=0. `in_ready`=0 while `rst`=1.
- Reset takes effect immediately, with no clock edge needed. A word in flight at reset assertion is discarded, and no accept is counted for that cycle.
- Latency: a word accepted at edge N appears on `out_valid[k]`/`out_data<k>` after edge N, i.e. one cycle.
- Throughput: one word per cycle to any port sequence, including back-to-back to the same port, while that consumer holds `out_ready` high.
- `in_ready` is combinational from `out_valid[sel]` and `out_ready[sel]`. This is the only combinational input-to-output path; there is no path from `in_valid` to `in_ready`.
- Upstream must hold `in_valid`, `in_data` and `sel` stable until accepted.
- `out_valid[k]` never drops without a drain or reset.

## Structure
- Shared package (`demux_pkg`):
  - `DEMUX_PORTS` = 4
  - `DEMUX_SEL_W` = 2
  - default `WIDTH` = 32
  - slot state encoding `SLOT_EMPTY` = 1'b0, `SLOT_FULL` = 1'b1
  - `XFER_CNT_W` = 16
- Sub-module `port_slot`: one-entry holding register with its EMPTY/FULL FSM.
  - Inputs: `clk`, `rst`, `load`, `load_data`, `drain`.
  - Outputs: `valid`, `data`.
  - Instantiated 4 times.
- Top level holds the select decode, `in_ready` logic and `xfer_cnt`.

## Test plan
- Reset, then `in_valid`=1, `sel`=2, `in_data`=32'hDEADBEEF, `out_ready`=4'b0000 -> next cycle `out_valid`=4'b0100, `out_data2`=DEADBEEF, `xfer_cnt`=1. Second word to `sel`=2 sees `in_ready`=0, and `out_data2` stays DEADBEEF.
- Port 2 FULL and stalled; send 32'h11 to `sel`=0 -> `in_ready`=1, next cycle `out_valid`=4'b0101, `out_data0`=32'h11.
- `out_ready`=4'b1111, stream 1,2,3,4 all to `sel`=1 on consecutive cycles -> `in_ready` high every cycle, `out_data1` shows 1,2,3,4 on consecutive cycles, `xfer_cnt`=4.
- Port 3 FULL with 32'hA; same cycle drain port 3 and accept 32'hB to `sel`=3 -> `out_valid[3]` stays 1, `out_data3`=32'hB, and no empty cycle appears.
- Preload `xfer_cnt`=65535 via 65535 accepts, then one more -> `xfer_cnt`=0.
- Fill all four ports, assert `rst` mid-cycle, without waiting for a clock edge -> `out_valid`=0, all `out_data`=0, `xfer_cnt`=0, `in_ready`=0 until `rst` drops.
